key_duty_ctrl: RTL and testbench

KEY_DUTY_CTRL -- requirements
Module: key_duty_ctrl

---
 rtl/key_duty_ctrl_pkg.sv | 21 ++
 rtl/key_debounce.sv | 59 +++++
 rtl/key_duty_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_key_duty_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/key_duty_ctrl_pkg.sv
// Shared definitions for the push-button duty controller: duty width and range,
// per-key FSM state encoding and a small helper for deriving counter widths.
package key_duty_ctrl_pkg;

    localparam int DUTY_W   = 10;
    localparam int DUTY_MAX = 1023;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

    // Largest of three cycle counts; used to size the shared counter width
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a level debouncer for one active-low key.
// The debounced level only follows the synchronised input after it has
// differed for DEB_CYCLES consecutive cycles; any bounce restarts the count.
module key_debounce
    import key_duty_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_n;
    logic             sync2_n;
    logic             level_n;
    logic [CNT_W-1:0] deb_cnt;

    // Bring the raw key into the clock domain; reset to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_n <= 1'b1;
            sync2_n <= 1'b1;
        end else begin
            sync1_n <= key_n;
            sync2_n <= sync1_n;
        end
    end

    // Accept a new level after a full run of differing samples; flag press edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_n     <= 1'b1;
            deb_cnt     <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sync2_n != level_n) begin
                if (deb_cnt == DEB_LAST) begin
                    level_n     <= sync2_n;
                    deb_cnt     <= '0;
                    press_pulse <= ~sync2_n;
                end else begin
                    deb_cnt <= deb_cnt + CNT_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign pressed = ~level_n;

endmodule

// File: rtl/key_duty_ctrl.sv
// Two-key duty controller: each debounced key drives an IDLE/HOLD/REPEAT FSM
// that issues step requests; a saturating accumulator applies them to duty.
// Index 0 is the up key, index 1 the down key.
module key_duty_ctrl
    import key_duty_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 50000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int RPT_CYCLES  = 2500000,
    parameter int STEP        = 8,
    parameter int DUTY_RST    = 1016
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_up_n,
    input  logic              key_dn_n,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic              at_limit
);

    localparam int CNT_W = $clog2(max3(DEB_CYCLES, HOLD_CYCLES, RPT_CYCLES) + 1);
    localparam int SUM_W = DUTY_W + 1;

    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RPT_LAST   = CNT_W'(RPT_CYCLES - 1);
    localparam logic [SUM_W-1:0]  STEP_EXT   = SUM_W'(STEP);
    localparam logic [SUM_W-1:0]  MAX_EXT    = SUM_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DUTY_TOP   = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DUTY_INIT  = DUTY_W'(DUTY_RST);
    localparam logic              LIMIT_INIT = (DUTY_RST == 0) || (DUTY_RST == DUTY_MAX);

    // Saturating increment in 11 bits: clamp at DUTY_MAX instead of wrapping
    function automatic logic [DUTY_W-1:0] sat_up(input logic [DUTY_W-1:0] d);
        logic [SUM_W-1:0] s;
        s = {1'b0, d} + STEP_EXT;
        if (s > MAX_EXT) return DUTY_TOP;
        return s[DUTY_W-1:0];
    endfunction

    // Saturating decrement in 11 bits: a borrow into the top bit means below zero
    function automatic logic [DUTY_W-1:0] sat_dn(input logic [DUTY_W-1:0] d);
        logic [SUM_W-1:0] s;
        s = {1'b0, d} - STEP_EXT;
        if (s[SUM_W-1]) return '0;
        return s[DUTY_W-1:0];
    endfunction

    logic [1:0]        key_pressed;
    logic [1:0]        key_pulse;
    logic [1:0]        step_req;
    logic              both_pressed;
    logic              block;
    logic              lock_q;
    key_state_t        state_q [2];
    key_state_t        state_d [2];
    logic [CNT_W-1:0]  cnt_q   [2];
    logic [CNT_W-1:0]  cnt_d   [2];
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_d;
    logic              upd_d;
    logic              upd_q;
    logic              limit_q;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deb_up (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_up_n),
        .pressed     (key_pressed[0]),
        .press_pulse (key_pulse[0])
    );

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deb_dn (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_dn_n),
        .pressed     (key_pressed[1]),
        .press_pulse (key_pulse[1])
    );

    // Both keys down blocks stepping until both are seen released again
    assign both_pressed = &key_pressed;
    assign block        = both_pressed | lock_q;

    // Latch the both-pressed condition until every key is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else if (both_pressed) begin
            lock_q <= 1'b1;
        end else if (key_pressed == 2'b00) begin
            lock_q <= 1'b0;
        end
    end

    // Per-key FSM state and hold/repeat counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    // Next-state and step requests: press steps once, hold delay, then periodic repeat
    always_comb begin
        step_req = 2'b00;
        for (int k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (block) begin
                state_d[k] = IDLE;
                cnt_d[k]   = '0;
            end else begin
                case (state_q[k])
                    IDLE: begin
                        if (key_pulse[k]) begin
                            state_d[k]  = HOLD;
                            cnt_d[k]    = '0;
                            step_req[k] = 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!key_pressed[k]) begin
                            state_d[k] = IDLE;
                            cnt_d[k]   = '0;
                        end else if (cnt_q[k] == HOLD_LAST) begin
                            state_d[k]  = REPEAT;
                            cnt_d[k]    = '0;
                            step_req[k] = 1'b1;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!key_pressed[k]) begin
                            state_d[k] = IDLE;
                            cnt_d[k]   = '0;
                        end else if (cnt_q[k] == RPT_LAST) begin
                            cnt_d[k]    = '0;
                            step_req[k] = 1'b1;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[k] = IDLE;
                        cnt_d[k]   = '0;
                    end
                endcase
            end
        end
    end

    // Apply at most one saturating step; an update is flagged only on real change
    always_comb begin
        duty_d = duty_q;
        if (step_req[0]) begin
            duty_d = sat_up(duty_q);
        end else if (step_req[1]) begin
            duty_d = sat_dn(duty_q);
        end
        upd_d = (duty_d != duty_q);
    end

    // Registered duty, update pulse and limit flag, all moving together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q  <= DUTY_INIT;
            upd_q   <= 1'b0;
            limit_q <= LIMIT_INIT;
        end else begin
            duty_q  <= duty_d;
            upd_q   <= upd_d;
            limit_q <= (duty_d == '0) || (duty_d == DUTY_TOP);
        end
    end

    assign duty     = duty_q;
    assign duty_upd = upd_q;
    assign at_limit = limit_q;

endmodule

// File: tb/tb_key_duty_ctrl.sv
// Directed bench for key_duty_ctrl with short debounce/hold/repeat timings.
module tb_key_duty_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic [9:0] duty;
    logic       duty_upd;
    logic       at_limit;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int upd_total = 0;
    int ev_t[$];
    int ev_d[$];

    typedef struct {
        logic up_n;
        logic dn_n;
        int   cycles;
        int   exp_upd;
        int   exp_duty;
        int   exp_lim;
    } vec_t;

    vec_t tbl[20];

    int exp_t[7] = '{7, 27, 32, 37, 42, 47, 52};
    int exp_d[7] = '{1008, 1000, 992, 984, 976, 968, 960};

    key_duty_ctrl #(
        .DEB_CYCLES  (4),
        .HOLD_CYCLES (20),
        .RPT_CYCLES  (5),
        .STEP        (8),
        .DUTY_RST    (1016)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_up_n (key_up_n),
        .key_dn_n (key_dn_n),
        .duty     (duty),
        .duty_upd (duty_upd),
        .at_limit (at_limit)
    );

    always #5 clk = ~clk;

    // Record every update pulse with its cycle stamp, sampled just after the edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (duty_upd === 1'b1) begin
            upd_total++;
            ev_t.push_back(cyc);
            ev_d.push_back(int'(duty));
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_duty(input int v, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (int'(duty) == v) break;
            run(1);
        end
        check(nm, int'(duty), v);
    endtask

    initial begin
        int base;
        int n0;
        int nev;

        tbl[0]  = '{1'b1, 1'b1,  5, 0, 1016, 0};
        tbl[1]  = '{1'b0, 1'b1, 10, 1, 1023, 1};
        tbl[2]  = '{1'b1, 1'b1, 10, 0, 1023, 1};
        for (int i = 0; i < 10; i++)
            tbl[3 + i] = '{1'b1, logic'(i % 2), 2, 0, 1023, 1};
        tbl[13] = '{1'b1, 1'b1, 10, 0, 1023, 1};
        tbl[14] = '{1'b0, 1'b0, 40, 0, 1023, 1};
        tbl[15] = '{1'b1, 1'b1, 10, 0, 1023, 1};
        tbl[16] = '{1'b1, 1'b0, 10, 1, 1015, 0};
        tbl[17] = '{1'b1, 1'b1, 10, 0, 1015, 0};
        tbl[18] = '{1'b0, 1'b1, 10, 1, 1023, 1};
        tbl[19] = '{1'b1, 1'b1, 10, 0, 1023, 1};

        // Reset state, during and just after release
        run(3);
        check("rst_duty", int'(duty), 1016);
        check("rst_upd", int'(duty_upd), 0);
        check("rst_lim", int'(at_limit), 0);
        rst_n = 1'b1;
        run(2);
        check("rel_duty", int'(duty), 1016);
        check("rel_upd", int'(duty_upd), 0);
        check("rel_lim", int'(at_limit), 0);

        // Table: single press, saturation, bounce, both-keys lockout, normal steps
        for (int r = 0; r < 20; r++) begin
            key_up_n = tbl[r].up_n;
            key_dn_n = tbl[r].dn_n;
            n0 = upd_total;
            run(tbl[r].cycles);
            check($sformatf("row%0d_upd", r), upd_total - n0, tbl[r].exp_upd);
            check($sformatf("row%0d_duty", r), int'(duty), tbl[r].exp_duty);
            check($sformatf("row%0d_lim", r), int'(at_limit), tbl[r].exp_lim);
        end

        // Back to 1016, then hold down: first step, hold delay, periodic repeats
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(2);
        check("hold_start", int'(duty), 1016);
        ev_t.delete();
        ev_d.delete();
        base = cyc;
        key_dn_n = 1'b0;
        run(50);
        key_dn_n = 1'b1;
        run(20);
        nev = ev_t.size();
        check("hold_nev", nev, 7);
        for (int i = 0; i < 7; i++) begin
            if (i < nev) begin
                check($sformatf("hold_t%0d", i), ev_t[i] - base, exp_t[i]);
                check($sformatf("hold_d%0d", i), ev_d[i], exp_d[i]);
            end
        end
        check("hold_end", int'(duty), 960);

        // Down to zero, repeat ticks at the limit stay silent, reset mid-repeat
        key_dn_n = 1'b0;
        wait_duty(8, 1500, "reach8");
        wait_duty(0, 100, "reach0");
        run(1);
        check("zero_lim", int'(at_limit), 1);
        n0 = upd_total;
        run(20);
        check("zero_noupd", upd_total - n0, 0);
        check("zero_duty", int'(duty), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_duty", int'(duty), 1016);
        check("mid_rst_upd", int'(duty_upd), 0);
        check("mid_rst_lim", int'(at_limit), 0);
        run(2);
        ev_t.delete();
        ev_d.delete();
        base = cyc;
        rst_n = 1'b1;
        run(10);
        nev = ev_t.size();
        check("repress_nev", nev, 1);
        if (nev > 0) begin
            check("repress_t", ev_t[0] - base, 7);
            check("repress_d", ev_d[0], 1008);
        end
        key_dn_n = 1'b1;
        run(10);
        check("final_duty", int'(duty), 1008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
